// File: rtl/imm_enc_pkg.sv
// Shared constants for the immediate encoder: format selects, opcodes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   INS_WIDTH, IMM_SEL        instruction width and format-select width
//   IMM_I..IMM_J              format select codes; other codes mean "no immediate"
//   OP_IMM, OP_LUI, F3_ADDI   opcode/funct3 constants used by constant-load expansion
//   state_t                   output FSM state encoding
//   sign_fits()               two's-complement range helper
package imm_enc_pkg;

    localparam int INS_WIDTH = 32;
    localparam int IMM_SEL   = 3;

    localparam logic [IMM_SEL-1:0] IMM_I = 3'd0;
    localparam logic [IMM_SEL-1:0] IMM_S = 3'd1;
    localparam logic [IMM_SEL-1:0] IMM_B = 3'd2;
    localparam logic [IMM_SEL-1:0] IMM_U = 3'd3;
    localparam logic [IMM_SEL-1:0] IMM_J = 3'd4;

    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [2:0] F3_ADDI = 3'b000;

    // IDLE: output register empty.
    // BEAT: output register holds the final beat of a request.
    // BEAT_HI: output register holds a LUI, its ADDI still pending.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BEAT    = 2'd1,
        ST_BEAT_HI = 2'd2
    } state_t;

    // True when v is representable as an n-bit signed value, i.e. bits
    // [31:n-1] are all copies of the sign bit. n is always a constant at
    // the call sites, so this folds to a simple all-zero/all-one compare.
    function automatic logic sign_fits(input logic [31:0] v, input int unsigned n);
        logic [31:0] upper;
        upper = 32'($signed(v) >>> (n - 1));
        return (upper == 32'h0000_0000) || (upper == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/imm_enc_pack.sv
// Combinational scatter of a 32-bit immediate into RISC-V I/S/B/U/J positions.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller registers the result.
//
// Ports:
//   base   instruction with immediate bits zero; result is base OR field bits
//   sel    format select (IMM_I..IMM_J); other codes return base unchanged
//   imm    immediate; bits outside the selected field are discarded
//   instr  encoded instruction
//   err    immediate does not fit the selected field (only when
//          IMM_ENC_RANGE_CHK_EN is defined; otherwise tied to 0)
module imm_pack
    import imm_enc_pkg::*;
(
    input  logic [INS_WIDTH-1:0] base,
    input  logic [IMM_SEL-1:0]   sel,
    input  logic [31:0]          imm,
    output logic [INS_WIDTH-1:0] instr,
    output logic                 err
);

    logic [INS_WIDTH-1:0] fld;

    always_comb begin
        fld = '0;
        case (sel)
            IMM_I: begin
                fld[31:20] = imm[11:0];
            end
            IMM_S: begin
                fld[31:25] = imm[11:5];
                fld[11:7]  = imm[4:0];
            end
            IMM_B: begin
                fld[31]    = imm[12];
                fld[7]     = imm[11];
                fld[30:25] = imm[10:5];
                fld[11:8]  = imm[4:1];
            end
            IMM_U: begin
                fld[31:12] = imm[31:12];
            end
            IMM_J: begin
                fld[31]    = imm[20];
                fld[19:12] = imm[19:12];
                fld[20]    = imm[11];
                fld[30:21] = imm[10:1];
            end
            default: begin
                fld = '0;
            end
        endcase
    end

    assign instr = base | fld;

`ifdef IMM_ENC_RANGE_CHK_EN
    // The instruction is emitted regardless; err only flags truncation.
    logic err_c;

    always_comb begin
        err_c = 1'b0;
        case (sel)
            IMM_I, IMM_S: err_c = !sign_fits(imm, 12);
            IMM_B:        err_c = !sign_fits(imm, 13) || imm[0];
            IMM_J:        err_c = !sign_fits(imm, 21) || imm[0];
            IMM_U:        err_c = (imm[11:0] != 12'h000);
            default:      err_c = 1'b0;
        endcase
    end

    assign err = err_c;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/imm_enc.sv
// Immediate encoder / constant-load expander, one instruction per output beat.
// Latency: 1 cycle accept->o_valid; second LI beat follows the cycle after beat 1 is taken.
// Backpressure: o_instr/o_last/o_err hold while o_valid && !i_ready; o_ready low while a LUI waits.
//
// Optional feature macro: IMM_ENC_RANGE_CHK_EN (range flag on o_err; tied 0 otherwise).
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_valid / o_ready     request handshake (accept = i_valid && o_ready)
//   i_imm_sel, i_li       format select; i_li selects constant-load expansion instead
//   i_base, i_imm         base instruction (LI uses only rd = [11:7]) and immediate
//   o_valid / i_ready     output beat handshake
//   o_instr, o_last,o_err encoded instruction, final-beat marker, range flag
module imm_enc
    import imm_enc_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [IMM_SEL-1:0]   i_imm_sel,
    input  logic                 i_li,
    input  logic [INS_WIDTH-1:0] i_base,
    input  logic [31:0]          i_imm,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [INS_WIDTH-1:0] o_instr,
    output logic                 o_last,
    output logic                 o_err
);

    state_t state_q, state_d;

    // Pending ADDI of a two-beat constant load.
    logic [4:0]  rd_q;
    logic [11:0] lo_q;

    logic [INS_WIDTH-1:0] instr_q;
    logic                 last_q;
    logic                 err_q;

    // Constant-load decode of the incoming request.
    logic [4:0]  rd_in;
    logic        li_fits;
    logic [19:0] li_hi;
    logic        li_two;

    assign rd_in   = i_base[11:7];
    assign li_fits = sign_fits(i_imm, 12);
    // ADDI sign-extends its 12-bit immediate, so LUI must pre-compensate
    // by one when bit 11 is set. Wraps mod 2^20 by construction.
    assign li_hi   = i_imm[31:12] + {19'd0, i_imm[11]};
    assign li_two  = !li_fits && (i_imm[11:0] != 12'h000);

    // Single packer shared by every beat type. In BEAT_HI no request can be
    // accepted (o_ready is 0), so the packer is free to build the pending ADDI.
    logic [INS_WIDTH-1:0] pk_base;
    logic [IMM_SEL-1:0]   pk_sel;
    logic [31:0]          pk_imm;
    logic                 pk_li;
    logic [INS_WIDTH-1:0] pk_instr;
    logic                 pk_err;

    always_comb begin
        pk_base = i_base;
        pk_sel  = i_imm_sel;
        pk_imm  = i_imm;
        pk_li   = 1'b0;
        if (state_q == ST_BEAT_HI) begin
            // ADDI rd, rd, lo
            pk_base = {12'd0, rd_q, F3_ADDI, rd_q, OP_IMM};
            pk_sel  = IMM_I;
            pk_imm  = {20'd0, lo_q};
            pk_li   = 1'b1;
        end else if (i_li) begin
            pk_li = 1'b1;
            if (li_fits) begin
                // ADDI rd, x0, imm
                pk_base = {12'd0, 5'd0, F3_ADDI, rd_in, OP_IMM};
                pk_sel  = IMM_I;
                pk_imm  = i_imm;
            end else begin
                // LUI rd, hi
                pk_base = {20'd0, rd_in, OP_LUI};
                pk_sel  = IMM_U;
                pk_imm  = {li_hi, 12'd0};
            end
        end
    end

    imm_pack u_pack (
        .base  (pk_base),
        .sel   (pk_sel),
        .imm   (pk_imm),
        .instr (pk_instr),
        .err   (pk_err)
    );

    // Handshake. o_ready depends only on state and i_ready.
    logic accept;

    assign o_ready = (state_q == ST_IDLE) || ((state_q == ST_BEAT) && i_ready);
    assign accept  = i_valid && o_ready;

    logic load_out;
    logic load_pend;
    logic last_d;
    logic err_d;

    // Constant-load beats are always in range by construction.
    assign err_d = pk_err && !pk_li;

    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_pend = 1'b0;
        last_d    = 1'b1;
        case (state_q)
            ST_IDLE, ST_BEAT: begin
                if (accept) begin
                    // A new accept in BEAT overwrites the beat being handed
                    // off this same cycle, keeping o_valid high.
                    load_out = 1'b1;
                    if (i_li && li_two) begin
                        state_d   = ST_BEAT_HI;
                        last_d    = 1'b0;
                        load_pend = 1'b1;
                    end else begin
                        state_d = ST_BEAT;
                    end
                end else if ((state_q == ST_BEAT) && i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BEAT_HI: begin
                if (i_ready) begin
                    load_out = 1'b1;
                    state_d  = ST_BEAT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 5'd0;
            lo_q    <= 12'd0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                instr_q <= pk_instr;
                last_q  <= last_d;
                err_q   <= err_d;
            end
            if (load_pend) begin
                rd_q <= rd_in;
                lo_q <= i_imm[11:0];
            end
        end
    end

    assign o_valid = (state_q != ST_IDLE);
    assign o_instr = instr_q;
    assign o_last  = last_q;
    assign o_err   = err_q;

endmodule

// File: doc/imm_enc.md
# imm_enc

Immediate encoder and constant-load expander for instruction generation paths such as the boot/self-test program writer and the trace-replay injector. It is the inverse of the decode-side immediate generator. It takes a base instruction with zeroed immediate fields, a format select and a 32-bit immediate, and scatters the immediate into the RISC-V I/S/B/U/J bit positions. In LI mode it expands a 32-bit constant load into one or two instructions (ADDI, or LUI then ADDI). Results go out one instruction per beat on a registered valid/ready stream.

## Interface
- INS_WIDTH, 32, instruction width (shared constant)
- IMM_SEL, 3, width of format select (shared constant)
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready
- i_imm_sel  in  IMM_SEL  IMM_I/IMM_S/IMM_B/IMM_U/IMM_J; other codes pass i_base unchanged
- i_li  in  1  constant-load expansion; overrides i_imm_sel
- i_base  in  INS_WIDTH  instruction with immediate bits zero; in LI mode only [11:7] (rd) is used
- i_imm  in  32  immediate / constant
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_instr  out  INS_WIDTH  encoded instruction
- o_last  out  1  final beat of this request
- o_err  out  1  range violation for this beat

## Operation
- Field packing, applied as o_instr = i_base OR field bits:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
- Bits outside a field are discarded.
- LI with rd=i_base[11:7]:
  - imm sign-fits 12 bits → single ADDI rd,x0,imm[11:0] (opcode 0010011, funct3 000, rs1 0).
  - Otherwise hi=imm[31:12]+imm[11], computed mod 2^20. Beat 1 is LUI rd,hi (opcode 0110111).
  - If imm[11:0]≠0, beat 2 is ADDI rd,rd,imm[11:0]; otherwise LUI alone is the last beat.
- FSM states:
  - IDLE: output empty.
  - BEAT: output holds the final beat.
  - BEAT_HI: output holds the LUI with the ADDI pending.
- Transitions:
  - Accept: load the output register. Go to BEAT_HI if two beats are required, else BEAT.
  - BEAT_HI && i_ready: load the ADDI and go to BEAT.
  - BEAT && i_ready with no new accept: go to IDLE.
- o_ready = IDLE || (BEAT && i_ready). This gives back-to-back single-beat throughput of one per cycle.
- o_ready is 0 in BEAT_HI.

## Timing
- Reset (i_rst_n=0 at a clock edge): state IDLE, o_valid=0, o_instr=0, o_last=0, o_err=0.
- A reset during BEAT_HI drops the pending ADDI.
- Latency is 1 cycle from accept to o_valid. The second LI beat appears in the cycle after the first beat is taken.
- Under backpressure (o_valid && !i_ready), o_instr, o_last and o_err hold stable.
- o_ready is combinational from state and i_ready. There is no combinational path from i_valid to any output.
- Simultaneous final-beat handoff and new accept: the new beat replaces the old one in the same cycle, and o_valid stays 1.

## Configuration
- IMM_ENC_RANGE_CHK_EN defined: o_err=1 on the beat when the immediate does not fit:
  - I/S: not sign-fit in 12 bits.
  - B: not sign-fit in 13 bits, or imm[0]≠0.
  - J: not sign-fit in 21 bits, or imm[0]≠0.
  - U: imm[11:0]≠0.
  - The instruction is still emitted with truncated fields.
  - LI beats never flag.
- Not defined: o_err is tied to 0 and no checker logic is built. The port list is unchanged.

## Structure
- Shared package/header holds IMM_I..IMM_J, INS_WIDTH, IMM_SEL, opcode constants OP_IMM=7'b0010011 and OP_LUI=7'b0110111, and the FSM state enum.
- One sub-module, imm_pack: combinational field scatter plus the optional range check. It is instantiated once and reused for the LI ADDI beat.

## Test plan
- I_base=0x00208063 (beq x1,x2), sel=B, imm=0xFFFFFFFC → o_instr=0xFE208EE3, o_last=1, o_err=0, one cycle after accept.
- LI, rd=10, imm=0xFFFFFFFB → single beat 0xFFB00513, o_last=1.
- LI, rd=5, imm=0x12345FFF, i_ready low for 3 cycles:
  - Beat 1 = 0x123462B7, held stable with o_last=0 and o_ready=0.
  - Beat 2 = 0xFFF28293 with o_last=1.
- LI, rd=5, imm=0x00001000 → single LUI 0x000012B7, o_last=1. Back-to-back I-format requests with i_ready=1 → one beat per cycle.
- With IMM_ENC_RANGE_CHK_EN: sel=I, imm=0x800 → field [31:20]=0x800, o_err=1. Without the macro the same stimulus gives o_err=0.
- Assert i_rst_n=0 while in BEAT_HI → next cycle o_valid=0, o_instr=0, no ADDI beat ever emitted, o_ready=1.
